// File: rtl/gamepad_sprite.sv
// Pixel-colour stage behind the VGA timing generator: moves a square sprite once per frame
// from synchronised gamepad buttons and drives 4-bit RGB, with a speed-up after a long hold.
module gamepad_sprite #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int STEP        = 4,
    parameter int HOLD_FRAMES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_active,
    input  logic       i_animate,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_btn_center,
    output logic [3:0] o_red,
    output logic [3:0] o_green,
    output logic [3:0] o_blue,
    output logic [9:0] o_sprite_x,
    output logic [8:0] o_sprite_y,
    output logic       o_fast
);

    localparam logic [9:0] X_MAX = 10'(SCREEN_W - SPRITE_W);
    localparam logic [8:0] Y_MAX = 9'(SCREEN_H - SPRITE_H);
    localparam logic [9:0] X_CTR = 10'((SCREEN_W - SPRITE_W) / 2);
    localparam logic [8:0] Y_CTR = 9'((SCREEN_H - SPRITE_H) / 2);
    localparam int CW = $clog2(HOLD_FRAMES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_FRAMES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_FAST = 2'd2;

    // Bit order: {center, right, left, down, up}
    logic [4:0] w_btn_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;

    assign w_btn_raw = {i_btn_center, i_btn_right, i_btn_left, i_btn_down, i_btn_up};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Opposing buttons cancel each other on their axis
    logic w_up, w_down, w_left, w_right, w_center, w_dir_any;
    assign w_up      = r_sync2[0] & ~r_sync2[1];
    assign w_down    = r_sync2[1] & ~r_sync2[0];
    assign w_left    = r_sync2[2] & ~r_sync2[3];
    assign w_right   = r_sync2[3] & ~r_sync2[2];
    assign w_center  = r_sync2[4];
    assign w_dir_any = w_up | w_down | w_left | w_right;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [9:0]    r_x;
    logic [8:0]    r_y;
    logic [9:0]    w_x_next;
    logic [8:0]    w_y_next;

    logic [10:0] w_step;
    logic [10:0] w_x_wide, w_y_wide, w_x_sum, w_y_sum;

    assign w_step   = (r_state == S_FAST) ? 11'(2 * STEP) : 11'(STEP);
    assign w_x_wide = {1'b0, r_x};
    assign w_y_wide = {2'b0, r_y};
    assign w_x_sum  = w_x_wide + w_step;
    assign w_y_sum  = w_y_wide + w_step;

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_left) begin
            w_x_next = (w_x_wide < w_step) ? 10'd0 : 10'(w_x_wide - w_step);
        end else if (w_right) begin
            w_x_next = (w_x_sum > {1'b0, X_MAX}) ? X_MAX : w_x_sum[9:0];
        end
        if (w_up) begin
            w_y_next = (w_y_wide < w_step) ? 9'd0 : 9'(w_y_wide - w_step);
        end else if (w_down) begin
            w_y_next = (w_y_sum > {2'b0, Y_MAX}) ? Y_MAX : w_y_sum[8:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_dir_any) begin
                    w_state_next = S_MOVE;
                    w_cnt_next   = CW'(1);
                end
            end
            S_MOVE: begin
                if (!w_dir_any) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_FAST;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_FAST: begin
                if (!w_dir_any) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Position only changes at animate (end of active area), so a frame never tears
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x     <= X_CTR;
            r_y     <= Y_CTR;
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (i_animate) begin
            if (w_center) begin
                r_x     <= X_CTR;
                r_y     <= Y_CTR;
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
            end
        end
    end

    logic [10:0] w_x_end, w_y_end;
    logic        w_inside;
    assign w_x_end  = w_x_wide + 11'(SPRITE_W);
    assign w_y_end  = w_y_wide + 11'(SPRITE_H);
    assign w_inside = (i_x >= r_x) && ({1'b0, i_x} < w_x_end) &&
                      (i_y >= r_y) && ({2'b0, i_y} < w_y_end);

    logic [3:0] r_red, r_green, r_blue;

    // One-strobe latency keeps colour aligned with the generator's registered syncs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (i_pix_stb) begin
            if (!i_active) begin
                r_red   <= 4'h0;
                r_green <= 4'h0;
                r_blue  <= 4'h0;
            end else if (w_inside) begin
                r_red   <= 4'hF;
                r_green <= 4'hF;
                r_blue  <= (r_state == S_FAST) ? 4'h0 : 4'hF;
            end else begin
                r_red   <= 4'h0;
                r_green <= 4'h0;
                r_blue  <= 4'h4;
            end
        end
    end

    assign o_red      = r_red;
    assign o_green    = r_green;
    assign o_blue     = r_blue;
    assign o_sprite_x = r_x;
    assign o_sprite_y = r_y;
    assign o_fast     = (r_state == S_FAST);

endmodule

// File: tb/tb_gamepad_sprite.sv
// Bench for gamepad_sprite: directed scenarios followed by random button/pixel traffic,
// checked against a frame-level model of sprite position, hold time and colour.
module tb_gamepad_sprite;

    localparam int SW = 640, SH = 480, PW = 32, PH = 32, STEP = 4, HOLD = 8;
    localparam int CX = (SW - PW) / 2, CY = (SH - PH) / 2;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_pix_stb = 1'b0, i_active = 1'b0, i_animate = 1'b0;
    logic [9:0] i_x = '0;
    logic [8:0] i_y = '0;
    logic       i_btn_up = 1'b0, i_btn_down = 1'b0, i_btn_left = 1'b0;
    logic       i_btn_right = 1'b0, i_btn_center = 1'b0;
    logic [3:0] o_red, o_green, o_blue;
    logic [9:0] o_sprite_x;
    logic [8:0] o_sprite_y;
    logic       o_fast;

    int checks = 0;
    int errors = 0;

    // Model: position plus number of consecutive animate ticks with a direction held
    int mx = CX, my = CY, mh = 0;

    always #5 clk = ~clk;

    gamepad_sprite dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_active(i_active),
        .i_animate(i_animate), .i_x(i_x), .i_y(i_y),
        .i_btn_up(i_btn_up), .i_btn_down(i_btn_down), .i_btn_left(i_btn_left),
        .i_btn_right(i_btn_right), .i_btn_center(i_btn_center),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_sprite_x(o_sprite_x), .o_sprite_y(o_sprite_y), .o_fast(o_fast)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit act);
        if (!act) return 12'h000;
        if (x >= mx && x < mx + PW && y >= my && y < my + PH)
            return (mh >= HOLD) ? 12'hFF0 : 12'hFFF;
        return 12'h004;
    endfunction

    task automatic model_step();
        int h, v, step;
        h = int'(i_btn_right) - int'(i_btn_left);
        v = int'(i_btn_down) - int'(i_btn_up);
        if (i_btn_center) begin
            mx = CX; my = CY; mh = 0;
        end else if (h != 0 || v != 0) begin
            step = (mh >= HOLD) ? 2 * STEP : STEP;
            mx = clamp(mx + h * step, SW - PW);
            my = clamp(my + v * step, SH - PH);
            mh++;
        end else begin
            mh = 0;
        end
    endtask

    task automatic set_buttons(input bit u, input bit d, input bit l, input bit r, input bit c);
        @(negedge clk);
        i_btn_up = u; i_btn_down = d; i_btn_left = l; i_btn_right = r; i_btn_center = c;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_pos(input string tag);
        check({tag, ".x"}, 32'(o_sprite_x), 32'(mx));
        check({tag, ".y"}, 32'(o_sprite_y), 32'(my));
        check({tag, ".fast"}, 32'(o_fast), 32'(mh >= HOLD));
    endtask

    task automatic animate(input string tag);
        @(negedge clk); i_animate = 1'b1;
        @(negedge clk); i_animate = 1'b0;
        model_step();
        check_pos(tag);
    endtask

    task automatic pixel(input string tag, input int x, input int y, input bit act);
        @(negedge clk);
        i_pix_stb = 1'b1; i_active = act; i_x = 10'(x); i_y = 9'(y);
        @(negedge clk);
        i_pix_stb = 1'b0;
        check(tag, 32'({o_red, o_green, o_blue}), 32'(exp_rgb(x, y, act)));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.rgb", 32'({o_red, o_green, o_blue}), 32'h000);
        check_pos("rst");
        i_rst = 1'b0;

        // Idle frames, then pixel classes
        animate("idle1");
        animate("idle2");
        check("idle.x_const", 32'(o_sprite_x), 32'd304);
        pixel("pix.sprite", 310, 230, 1'b1);
        check("pix.sprite_const", 32'({o_red, o_green, o_blue}), 32'hFFF);
        // Colour must hold while the strobe is low
        @(negedge clk); i_x = 10'd0; i_active = 1'b1;
        @(negedge clk);
        check("pix.hold", 32'({o_red, o_green, o_blue}), 32'hFFF);
        pixel("pix.bg", 0, 0, 1'b1);
        check("pix.bg_const", 32'({o_red, o_green, o_blue}), 32'h004);
        pixel("pix.blank", 310, 230, 1'b0);
        pixel("pix.edge_in", CX + PW - 1, CY + PH - 1, 1'b1);
        pixel("pix.edge_out_x", CX + PW, CY, 1'b1);
        pixel("pix.edge_out_y", CX, CY + PH, 1'b1);
        pixel("pix.left_out", CX - 1, CY, 1'b1);

        // Hold right 3 frames, then release
        set_buttons(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) animate("right");
        check("right.x_const", 32'(o_sprite_x), 32'd316);
        set_buttons(0, 0, 0, 0, 0);
        animate("release");
        check("release.x_const", 32'(o_sprite_x), 32'd316);

        // Recentre, then hold left through the speed-up
        set_buttons(0, 0, 0, 0, 1);
        animate("center1");
        set_buttons(0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) animate("left_slow");
        check("left.x272", 32'(o_sprite_x), 32'd272);
        check("left.fast_on", 32'(o_fast), 32'd1);
        for (int i = 0; i < 12; i++) animate("left_fast");
        pixel("pix.fast_sprite", mx + 5, my + 5, 1'b1);
        check("pix.fast_const", 32'({o_red, o_green, o_blue}), 32'hFF0);

        // Asynchronous reset in the middle of an active line while FAST
        @(negedge clk); i_pix_stb = 1'b1; i_active = 1'b1; i_x = 10'(mx + 1); i_y = 9'(my + 1);
        @(posedge clk); #3;
        i_rst = 1'b1;
        #1;
        check("arst.rgb", 32'({o_red, o_green, o_blue}), 32'h000);
        check("arst.fast", 32'(o_fast), 32'd0);
        check("arst.x", 32'(o_sprite_x), 32'(CX));
        check("arst.y", 32'(o_sprite_y), 32'(CY));
        @(negedge clk); i_rst = 1'b0; i_pix_stb = 1'b0;
        mx = CX; my = CY; mh = 0;
        set_buttons(0, 0, 0, 0, 0);
        pixel("arst.resume", 310, 230, 1'b1);

        // Clamp at the top and right edges
        set_buttons(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) animate("up_clamp");
        check("up.y0", 32'(o_sprite_y), 32'd0);
        set_buttons(0, 0, 0, 0, 0);
        animate("rel2");
        set_buttons(0, 0, 0, 1, 0);
        for (int i = 0; i < 50; i++) animate("right_clamp");
        check("right.x608", 32'(o_sprite_x), 32'd608);

        // Opposing vertical buttons cancel; centre overrides directions
        set_buttons(0, 0, 0, 0, 1);
        animate("center2");
        set_buttons(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) animate("updown_right");
        check("updown.y", 32'(o_sprite_y), 32'd224);
        check("updown.x", 32'(o_sprite_x), 32'd316);
        set_buttons(0, 0, 0, 1, 1);
        animate("center3");
        check("center3.x", 32'(o_sprite_x), 32'd304);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            set_buttons($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
            for (int f = 0; f < int'($urandom_range(1, 4)); f++) animate("rand");
            if ($urandom_range(0, 1) == 1)
                pixel("rand.pix_in", mx + int'($urandom_range(0, PW - 1)),
                      my + int'($urandom_range(0, PH - 1)), $urandom_range(0, 3) != 0);
            else
                pixel("rand.pix", int'($urandom_range(0, SW - 1)), int'($urandom_range(0, SH - 1)),
                      $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
